mdu_iter: RTL and testbench

- Multi-cycle multiply/divide responder for the pipelined CPU.
- The EX stage initiates an operation with a start pulse and holds the pipeline on stall_o until the result returns with a one-cycle valid_o pulse.
- Replaces the single-cycle combinational multiply path with a shift-add multiplier and a restoring divider.
- Also provides quotient and remainder.

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_step.sv | 69 ++++++
 rtl/mdu_iter.sv | 239 +++++++++++++++++++++++
 tb/tb_mdu_iter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - operation encodings (MDU_OP_*) as driven on op_i
//   - FSM state encodings (MDU_IDLE / MDU_RUN / MDU_DONE)
//   - default operand width
//   - is_div_op(): true for operations that use the divider datapath
// Optional feature macro used by the users of this package: MDU_SIGNED_EN.
package mdu_pkg;

  localparam int MDU_WIDTH_DFLT = 32;

  typedef enum logic [1:0] {
    MDU_OP_MUL = 2'b00,
    MDU_OP_DIV = 2'b01,
    MDU_OP_REM = 2'b10,
    MDU_OP_RSV = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_RUN  = 2'b01,
    MDU_DONE = 2'b10
  } mdu_state_e;

  function automatic logic is_div_op(input mdu_op_e op);
    return (op == MDU_OP_DIV) || (op == MDU_OP_REM);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one combinational iteration of the multiply/divide datapath.
// Ports:
//   op      : operation being iterated (mdu_op_e)
//   acc     : accumulator (MUL) or partial remainder (DIV/REM)
//   opa     : multiplicand (MUL) or dividend/quotient shift register (DIV/REM)
//   opb     : multiplier (MUL) or divisor (DIV/REM)
//   acc_nxt, opa_nxt, opb_nxt : values after this iteration
// The divider reuses opa as a combined dividend/quotient register: each
// iteration shifts the dividend MSB out into the remainder and the new
// quotient bit in at the LSB, so after WIDTH steps opa holds the quotient.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH_DFLT
) (
  input  mdu_op_e          op,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] opa_nxt,
  output logic [WIDTH-1:0] opb_nxt
);

  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH-1:0] diff_s;

  // Shifted partial remainder and trial difference for the restoring divider.
  // When the subtraction is kept the true difference is below the divisor,
  // so a WIDTH-bit modular subtract gives the exact result.
  always_comb begin
    rem_sh_s = {acc, opa[WIDTH-1]};
    diff_s   = rem_sh_s[WIDTH-1:0] - opb;
  end

  // Single shift-add (MUL) or compare-subtract (DIV/REM) iteration.
  always_comb begin
    acc_nxt = acc;
    opa_nxt = opa;
    opb_nxt = opb;
    case (op)
      MDU_OP_MUL: begin
        if (opb[0]) begin
          acc_nxt = acc + opa;
        end else begin
          acc_nxt = acc;
        end
        opa_nxt = {opa[WIDTH-2:0], 1'b0};
        opb_nxt = {1'b0, opb[WIDTH-1:1]};
      end
      MDU_OP_DIV, MDU_OP_REM: begin
        if (rem_sh_s >= {1'b0, opb}) begin
          acc_nxt = diff_s;
          opa_nxt = {opa[WIDTH-2:0], 1'b1};
        end else begin
          acc_nxt = rem_sh_s[WIDTH-1:0];
          opa_nxt = {opa[WIDTH-2:0], 1'b0};
        end
        opb_nxt = opb;
      end
      default: begin
        acc_nxt = acc;
        opa_nxt = opa;
        opb_nxt = opb;
      end
    endcase
  end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle multiply / divide / remainder unit.
// Ports:
//   clk_i      : clock, all state updates on the rising edge
//   rst_i      : synchronous active-low reset
//   start_i    : request strobe, accepted in IDLE or DONE
//   op_i       : 00 MUL, 01 DIV, 10 REM, 11 reserved (result 0)
//   data1_i    : multiplicand / dividend, sampled at accept
//   data2_i    : multiplier / divisor, sampled at accept
//   stall_o    : high from the cycle after accept through the last RUN cycle
//   valid_o    : one-cycle result strobe (the DONE cycle)
//   data_o     : result, held until the next completion
//   div_zero_o : DIV/REM by zero, qualified by valid_o
// Every operation takes exactly WIDTH RUN cycles; there is no early exit.
// Define MDU_SIGNED_EN for two's-complement operands: magnitudes are
// iterated and the sign is fixed up when the result is registered.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH_DFLT,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             stall_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             div_zero_o
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};

  mdu_state_e       state_r;
  mdu_state_e       state_nxt_s;
  logic             accept_s;
  logic             last_s;
  logic [CNT_W-1:0] cnt_r;
  mdu_op_e          op_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] opa_r;
  logic [WIDTH-1:0] opb_r;
  logic             dz_r;
  logic [WIDTH-1:0] opa_ld_s;
  logic [WIDTH-1:0] opb_ld_s;
  logic [WIDTH-1:0] acc_nxt_s;
  logic [WIDTH-1:0] opa_nxt_s;
  logic [WIDTH-1:0] opb_nxt_s;
  logic [WIDTH-1:0] result_s;
  logic             stall_r;
  logic             valid_r;
  logic [WIDTH-1:0] data_r;
  logic             div_zero_r;

`ifdef MDU_SIGNED_EN
  logic neg1_r;
  logic neg2_r;

  // Two's-complement negate when c is set; also used as absolute value.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic c);
    if (c) begin
      return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction
`endif

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_r),
    .acc     (acc_r),
    .opa     (opa_r),
    .opb     (opb_r),
    .acc_nxt (acc_nxt_s),
    .opa_nxt (opa_nxt_s),
    .opb_nxt (opb_nxt_s)
  );

  // Last RUN iteration: counter about to reach zero.
  always_comb begin
    last_s = (cnt_r == CNT_ONE);
  end

  // Next-state logic; start_i is only honoured in IDLE and DONE.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      MDU_IDLE: begin
        if (start_i) begin
          accept_s    = 1'b1;
          state_nxt_s = MDU_RUN;
        end else begin
          state_nxt_s = MDU_IDLE;
        end
      end
      MDU_RUN: begin
        if (last_s) begin
          state_nxt_s = MDU_DONE;
        end else begin
          state_nxt_s = MDU_RUN;
        end
      end
      MDU_DONE: begin
        if (start_i) begin
          accept_s    = 1'b1;
          state_nxt_s = MDU_RUN;
        end else begin
          state_nxt_s = MDU_IDLE;
        end
      end
      default: begin
        state_nxt_s = MDU_IDLE;
      end
    endcase
  end

  // Operand values loaded at accept (magnitudes in signed builds).
  always_comb begin
`ifdef MDU_SIGNED_EN
    opa_ld_s = neg_if(data1_i, data1_i[WIDTH-1]);
    opb_ld_s = neg_if(data2_i, data2_i[WIDTH-1]);
`else
    opa_ld_s = data1_i;
    opb_ld_s = data2_i;
`endif
  end

  // Final result from the last iteration's outputs, including sign fix-up.
  // Divide by zero falls out of the restoring loop naturally (quotient all
  // ones, remainder = dividend) but the quotient is forced so the signed
  // build does not negate it.
  always_comb begin
    result_s = ALL_ZERO;
    case (op_r)
      MDU_OP_MUL: begin
`ifdef MDU_SIGNED_EN
        result_s = neg_if(acc_nxt_s, neg1_r ^ neg2_r);
`else
        result_s = acc_nxt_s;
`endif
      end
      MDU_OP_DIV: begin
        if (dz_r) begin
          result_s = ALL_ONES;
        end else begin
`ifdef MDU_SIGNED_EN
          result_s = neg_if(opa_nxt_s, neg1_r ^ neg2_r);
`else
          result_s = opa_nxt_s;
`endif
        end
      end
      MDU_OP_REM: begin
`ifdef MDU_SIGNED_EN
        result_s = neg_if(acc_nxt_s, neg1_r);
`else
        result_s = acc_nxt_s;
`endif
      end
      MDU_OP_RSV: begin
        result_s = ALL_ZERO;
      end
      default: begin
        result_s = ALL_ZERO;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r <= MDU_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Counter and operand registers: load at accept, iterate while running.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_r  <= {CNT_W{1'b0}};
      op_r   <= MDU_OP_MUL;
      acc_r  <= ALL_ZERO;
      opa_r  <= ALL_ZERO;
      opb_r  <= ALL_ZERO;
      dz_r   <= 1'b0;
`ifdef MDU_SIGNED_EN
      neg1_r <= 1'b0;
      neg2_r <= 1'b0;
`endif
    end else if (accept_s) begin
      cnt_r  <= CNT_LOAD;
      op_r   <= mdu_op_e'(op_i);
      acc_r  <= ALL_ZERO;
      opa_r  <= opa_ld_s;
      opb_r  <= opb_ld_s;
      dz_r   <= is_div_op(mdu_op_e'(op_i)) && (data2_i == ALL_ZERO);
`ifdef MDU_SIGNED_EN
      neg1_r <= data1_i[WIDTH-1];
      neg2_r <= data2_i[WIDTH-1];
`endif
    end else if (state_r == MDU_RUN) begin
      cnt_r <= cnt_r - CNT_ONE;
      acc_r <= acc_nxt_s;
      opa_r <= opa_nxt_s;
      opb_r <= opb_nxt_s;
    end
  end

  // Registered handshake and result outputs; result/flag hold until the
  // next completion.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_r    <= 1'b0;
      valid_r    <= 1'b0;
      data_r     <= ALL_ZERO;
      div_zero_r <= 1'b0;
    end else begin
      stall_r <= (state_nxt_s == MDU_RUN);
      valid_r <= (state_r == MDU_RUN) && last_s;
      if ((state_r == MDU_RUN) && last_s) begin
        data_r     <= result_s;
        div_zero_r <= dz_r;
      end
    end
  end

  assign stall_o    = stall_r;
  assign valid_o    = valid_r;
  assign data_o     = data_r;
  assign div_zero_o = div_zero_r;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed + randomized self-checking bench for mdu_iter.
// Expected results come from plain arithmetic on the operands; the bench
// follows the same MDU_SIGNED_EN macro as the design.
module tb_mdu_iter;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [1:0]    op_i;
  logic [W-1:0]  data1_i;
  logic [W-1:0]  data2_i;
  logic          stall_o;
  logic          valid_o;
  logic [W-1:0]  data_o;
  logic          div_zero_o;

  int n_checks = 0;
  int n_fails  = 0;

  mdu_iter #(.WIDTH(W), .CNT_W(6)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .op_i       (op_i),
    .data1_i    (data1_i),
    .data2_i    (data2_i),
    .stall_o    (stall_o),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .div_zero_o (div_zero_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the operands.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b, output logic dz);
    logic [31:0] r;
`ifdef MDU_SIGNED_EN
    longint sa;
    longint sb;
    longint t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
`endif
    dz = ((op == 2'd1) || (op == 2'd2)) && (b == 32'd0);
    r  = 32'd0;
    if (op == 2'd0) begin
      r = a * b;
    end else if (op == 2'd1) begin
      if (b == 32'd0) r = 32'hFFFF_FFFF;
      else begin
`ifdef MDU_SIGNED_EN
        t = sa / sb;
        r = t[31:0];
`else
        r = a / b;
`endif
      end
    end else if (op == 2'd2) begin
      if (b == 32'd0) r = a;
      else begin
`ifdef MDU_SIGNED_EN
        t = sa % sb;
        r = t[31:0];
`else
        r = a % b;
`endif
      end
    end
    return r;
  endfunction

  // Issue one request (from IDLE or DONE) and check handshake, latency and result.
  // Returns just after the edge that enters DONE.
  task automatic run_op(input logic [1:0] op, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] exp, input logic exp_dz, input string tag);
    int lat;
    @(negedge clk);
    start_i = 1'b1; op_i = op; data1_i = d1; data2_i = d2;
    @(negedge clk);
    start_i = 1'b0;
    chk({31'd0, stall_o}, 32'd1, {tag, "_stall_after_accept"});
    chk({31'd0, valid_o}, 32'd0, {tag, "_valid_after_accept"});
    lat = 0;
    while (!valid_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    // accept at edge N -> valid_o visible right after edge N+W
    chk(lat, W, {tag, "_latency"});
    chk(data_o, exp, {tag, "_data"});
    chk({31'd0, div_zero_o}, {31'd0, exp_dz}, {tag, "_div_zero"});
    chk({31'd0, stall_o}, 32'd0, {tag, "_stall_at_done"});
  endtask

  initial begin
    logic        mdz;
    logic [31:0] mexp;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          nval;
    int          lat;

    rst_i = 1'b0; start_i = 1'b0; op_i = 2'd0; data1_i = 32'd0; data2_i = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk({31'd0, stall_o}, 32'd0, "reset_stall");
    chk({31'd0, valid_o}, 32'd0, "reset_valid");
    chk(data_o, 32'd0, "reset_data");
    chk({31'd0, div_zero_o}, 32'd0, "reset_div_zero");
    @(negedge clk);
    rst_i = 1'b1;

    // Directed MUL / DIV / REM / divide-by-zero / reserved
    run_op(2'd0, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 1'b0, "mul_basic");
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "mul_trunc");
    run_op(2'd1, 32'd100, 32'd7, 32'd14, 1'b0, "div_100_7");
    run_op(2'd2, 32'd100, 32'd7, 32'd2, 1'b0, "rem_100_7");
    run_op(2'd1, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1'b1, "div_zero");
    run_op(2'd2, 32'h0000_1234, 32'd0, 32'h0000_1234, 1'b1, "rem_zero");
    run_op(2'd3, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b0, "reserved");
`ifdef MDU_SIGNED_EN
    run_op(2'd1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, "sdiv_m7_2");
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, "srem_m7_2");
    run_op(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, "sdiv_ovf");
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "srem_ovf");
    run_op(2'd1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1'b1, "sdiv_zero");
    run_op(2'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b1, "srem_zero");
    run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0, "smul_m3_5");
`endif

    // Randomized operations against the reference; consecutive calls are
    // back-to-back accepts from DONE.
    for (int i = 0; i < 20; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 15));
      else rb = $urandom;
      if ($urandom_range(0, 4) == 0) ra = 32'($urandom_range(0, 255));
      mexp = model(rop, ra, rb, mdz);
      run_op(rop, ra, rb, mexp, mdz, $sformatf("rand%0d_op%0d", i, rop));
    end

    // start_i held high through RUN: one accept, one valid_o
    @(negedge clk);
    start_i = 1'b1; op_i = 2'd1; data1_i = 32'd1000; data2_i = 32'd10;
    @(negedge clk);
    nval = 0; lat = 0;
    while (nval == 0 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (valid_o) nval++;
    end
    @(negedge clk);
    start_i = 1'b0;
    // result must hold while idle
    repeat (5) begin
      @(posedge clk); #1;
      if (valid_o) nval++;
    end
    chk(lat, W, "held_start_latency");
    chk(nval, 32'd1, "held_start_valid_count");
    chk(data_o, 32'd100, "held_start_result_hold");
    chk({31'd0, stall_o}, 32'd0, "held_start_idle_stall");

    // Reset in the middle of a multiply: abort without any valid_o
    @(negedge clk);
    start_i = 1'b1; op_i = 2'd0; data1_i = 32'd7; data2_i = 32'd6;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    rst_i = 1'b0;
    @(posedge clk); #1;
    chk({31'd0, stall_o}, 32'd0, "midrun_reset_stall");
    chk(data_o, 32'd0, "midrun_reset_data");
    chk({31'd0, valid_o}, 32'd0, "midrun_reset_valid");
    @(negedge clk);
    rst_i = 1'b1;
    nval = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid_o) nval++;
    end
    chk(nval, 32'd0, "midrun_reset_no_valid");

    // Unit still works after the abort
    run_op(2'd0, 32'd7, 32'd6, 32'd42, 1'b0, "mul_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
